mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_ctrl_pkg.sv | 49 ++++
 rtl/lane_merge.sv | 41 ++++
 rtl/mem_access_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared opcodes, FSM states and access-size helpers for the load/store memory controller.
package mem_ctrl_pkg;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_LH = 6'b100001;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_SB = 6'b101000;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    function automatic logic op_known(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_LH) ||
               (op == OP_SH) || (op == OP_LB) || (op == OP_SB);
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic size_t op_size(input logic [5:0] op);
        if (op == OP_LW || op == OP_SW)
            return SZ_WORD;
        else if (op == OP_LH || op == OP_SH)
            return SZ_HALF;
        else
            return SZ_BYTE;
    endfunction

    // Low address bits that are ignored for the access size are forced to zero.
    function automatic logic [1:0] eff_lane(input size_t sz, input logic [1:0] a);
        case (sz)
            SZ_WORD: return 2'b00;
            SZ_HALF: return {a[1], 1'b0};
            default: return a;
        endcase
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [1:0] a);
        case (sz)
            SZ_WORD: return |a;
            SZ_HALF: return a[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lane_merge.sv
// Little-endian lane extract (sign-extended load result) and lane merge (store word).
module lane_merge
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  size_t       i_size,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_lane, 3'b000} +: 8];
    assign w_half = i_word[{i_lane[1], 4'b0000} +: 16];

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        o_load   = i_word;
        o_merged = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load   = {{24{w_byte[7]}}, w_byte};
                o_merged = i_word;
                o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load   = {{16{w_half[15]}}, w_half};
                o_merged = i_word;
                o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: begin
                o_load   = i_word;
                o_merged = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller with read-modify-write for sub-word stores.
// Define MEM_ACCESS_CTRL_MISALIGN_CHK_EN to reject misaligned word/half accesses.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_opcode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_err
);

    state_t            r_state;
    state_t            w_next;
    logic [5:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_req_err;
    logic [31:0]       w_load;
    logic [31:0]       w_merged;

`ifdef MEM_ACCESS_CTRL_MISALIGN_CHK_EN
    assign w_req_err = !op_known(req_opcode) ||
                       misaligned(op_size(req_opcode), req_addr[1:0]);
`else
    assign w_req_err = !op_known(req_opcode);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_op    <= req_opcode;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_err   <= w_req_err;
            end
            if (r_state == RD && mem_ack)
                r_rdata <= mem_rdata;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_req_err)
                        w_next = RESP;
                    else if (req_opcode == OP_SW)
                        w_next = WR;
                    else
                        w_next = RD;
                end
            end
            RD:      if (mem_ack) w_next = op_is_store(r_op) ? WR : RESP;
            WR:      if (mem_ack) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    lane_merge u_lane_merge (
        .i_word   (r_rdata),
        .i_wdata  (r_wdata),
        .i_size   (op_size(r_op)),
        .i_lane   (eff_lane(op_size(r_op), r_addr[1:0])),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    // Outputs decode from state alone, so an async reset clears them immediately.
    always_comb begin
        req_ready  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_err   = 1'b0;
        case (r_state)
            IDLE: req_ready = 1'b1;
            RD: begin
                mem_rd_en = 1'b1;
                mem_addr  = r_addr[ADDR_W-1:2];
            end
            WR: begin
                mem_wr_en = 1'b1;
                mem_addr  = r_addr[ADDR_W-1:2];
                mem_wdata = w_merged;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_data  = (r_err || op_is_store(r_op)) ? 32'h0 : w_load;
            end
            default: req_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Table-driven bench for mem_access_ctrl with a response scoreboard and a delay-programmable memory responder.
module tb_mem_access_ctrl;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opcode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          rd_dly;
        int          wr_dly;
        logic [31:0] exp_data;
        logic        exp_err;
        int          n_rd;
        int          n_wr;
        logic [31:0] exp_wdata;
        logic [29:0] exp_maddr;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    vec_t  vecs[$];
    resp_t sb_q[$];
    resp_t mon_e;

    int n_vec  = 0;
    int n_miss = 0;

    int          rd_dly_cfg = 0;
    int          wr_dly_cfg = 0;
    logic [31:0] rword_cfg  = '0;
    int          rd_cycles  = 0;
    int          wr_cycles  = 0;
    int          wr_done    = 0;
    int          resp_cnt   = 0;
    logic        both_hi    = 1'b0;
    logic [31:0] last_wdata = '0;
    logic [29:0] last_maddr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rword, input int rd_dly, input int wr_dly,
                                input logic [31:0] exp_data, input logic exp_err, input int n_rd,
                                input int n_wr, input logic [31:0] exp_wdata, input logic [29:0] exp_maddr);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rword = rword;
        v.rd_dly = rd_dly; v.wr_dly = wr_dly; v.exp_data = exp_data; v.exp_err = exp_err;
        v.n_rd = n_rd; v.n_wr = n_wr; v.exp_wdata = exp_wdata; v.exp_maddr = exp_maddr;
        return v;
    endfunction

    // Memory model: acks after the programmed number of wait cycles, read data is junk except on ack.
    always @(negedge Clk) begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hA5A5_A5A5;
        if (mem_rd_en && mem_wr_en)
            both_hi = 1'b1;
        if (mem_rd_en) begin
            rd_cycles++;
            if (rd_cycles == rd_dly_cfg + 1) begin
                mem_ack    = 1'b1;
                mem_rdata  = rword_cfg;
                last_maddr = mem_addr;
            end
        end else if (mem_wr_en) begin
            wr_cycles++;
            if (wr_cycles == wr_dly_cfg + 1) begin
                mem_ack    = 1'b1;
                last_wdata = mem_wdata;
                last_maddr = mem_addr;
                wr_done++;
            end
        end
    end

    always @(negedge Clk) begin
        if (Rst_n && resp_valid) begin
            resp_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected resp_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("resp_data", resp_data, mon_e.data);
                check("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge Clk);
            guard++;
        end
        if (!req_ready)
            check("req_ready timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int cnt0;
        int exp_lat;
        wait_ready();
        rd_dly_cfg = v.rd_dly;
        wr_dly_cfg = v.wr_dly;
        rword_cfg  = v.rword;
        rd_cycles  = 0;
        wr_cycles  = 0;
        cnt0       = resp_cnt;
        req_valid  = 1'b1;
        req_opcode = v.op;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        sb_q.push_back('{data: v.exp_data, err: v.exp_err});
        exp_lat = 1 + v.n_rd * (v.rd_dly + 1) + v.n_wr * (v.wr_dly + 1);
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
            if (lat == 1)
                req_valid = 1'b0;
        end while (!resp_valid && lat < 40);
        if (!resp_valid) begin
            check({tag, " resp timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " rd strobe cycles"}, rd_cycles, v.n_rd * (v.rd_dly + 1));
        check({tag, " wr strobe cycles"}, wr_cycles, v.n_wr * (v.wr_dly + 1));
        if (v.n_wr != 0)
            check({tag, " mem_wdata"}, last_wdata, v.exp_wdata);
        if (v.n_rd + v.n_wr != 0)
            check({tag, " mem_addr"}, {2'b00, last_maddr}, {2'b00, v.exp_maddr});
        @(negedge Clk);
        check({tag, " single resp pulse"}, resp_cnt - cnt0, 32'd1);
        check({tag, " ready after resp"}, {31'd0, req_ready}, 32'd1);
    endtask

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, LH = 6'b100001;
    localparam logic [5:0] SH = 6'b101001, LB = 6'b100000, SB = 6'b101000;

    initial begin
        int wr0;
        int cnt0;
        int guard;

        vecs.push_back(mk(LW, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 1'b0, 1, 0, 32'h0,        30'h4));
        vecs.push_back(mk(SB, 32'h22, 32'h000000AA, 32'h11223344, 0, 0, 32'h0,        1'b0, 1, 1, 32'h11AA3344, 30'h8));
        vecs.push_back(mk(LH, 32'h06, 32'h0,        32'h80011234, 0, 0, 32'hFFFF8001, 1'b0, 1, 0, 32'h0,        30'h1));
        vecs.push_back(mk(LB, 32'h04, 32'h0,        32'h80011234, 0, 0, 32'h00000034, 1'b0, 1, 0, 32'h0,        30'h1));
        vecs.push_back(mk(SH, 32'h00, 32'h1234ABCD, 32'hCAFE5678, 3, 2, 32'h0,        1'b0, 1, 1, 32'hCAFEABCD, 30'h0));
        vecs.push_back(mk(6'b000000, 32'h10, 32'h0, 32'h0,        0, 0, 32'h0,        1'b1, 0, 0, 32'h0,        30'h0));
        vecs.push_back(mk(6'b101111, 32'h10, 32'h0, 32'h0,        0, 0, 32'h0,        1'b1, 0, 0, 32'h0,        30'h0));
        vecs.push_back(mk(SW, 32'h0C, 32'h55AA55AA, 32'h0,        0, 1, 32'h0,        1'b0, 0, 1, 32'h55AA55AA, 30'h3));
        vecs.push_back(mk(LB, 32'h07, 32'h0,        32'h80112233, 0, 0, 32'hFFFFFF80, 1'b0, 1, 0, 32'h0,        30'h1));
        vecs.push_back(mk(LB, 32'h05, 32'h0,        32'h80112233, 0, 0, 32'h00000022, 1'b0, 1, 0, 32'h0,        30'h1));
        vecs.push_back(mk(LH, 32'h02, 32'h0,        32'h7FFF8000, 0, 0, 32'h00007FFF, 1'b0, 1, 0, 32'h0,        30'h0));
        vecs.push_back(mk(SB, 32'h03, 32'hFFFFFF5A, 32'h11223344, 0, 0, 32'h0,        1'b0, 1, 1, 32'h5A223344, 30'h0));
        vecs.push_back(mk(SH, 32'h02, 32'h0000BEEF, 32'h11223344, 1, 0, 32'h0,        1'b0, 1, 1, 32'hBEEF3344, 30'h0));
        vecs.push_back(mk(LW, 32'h40, 32'h0,        32'h0BADF00D, 2, 0, 32'h0BADF00D, 1'b0, 1, 0, 32'h0,        30'h10));
`ifdef MEM_ACCESS_CTRL_MISALIGN_CHK_EN
        vecs.push_back(mk(LW, 32'h13, 32'h0,        32'h01020304, 0, 0, 32'h0,        1'b1, 0, 0, 32'h0,        30'h0));
        vecs.push_back(mk(LH, 32'h07, 32'h0,        32'h80011234, 0, 0, 32'h0,        1'b1, 0, 0, 32'h0,        30'h0));
`else
        vecs.push_back(mk(LW, 32'h13, 32'h0,        32'h01020304, 0, 0, 32'h01020304, 1'b0, 1, 0, 32'h0,        30'h4));
        vecs.push_back(mk(LH, 32'h07, 32'h0,        32'h80011234, 0, 0, 32'hFFFF8001, 1'b0, 1, 0, 32'h0,        30'h1));
`endif

        Rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_opcode = '0;
        req_addr   = '0;
        req_wdata  = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        #1;
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        check("reset resp", {31'd0, resp_valid}, 32'd0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while an SB write is waiting on its ack: nothing completes, nothing is retried.
        wait_ready();
        rd_dly_cfg = 0;
        wr_dly_cfg = 5;
        rword_cfg  = 32'h11223344;
        rd_cycles  = 0;
        wr_cycles  = 0;
        wr0        = wr_done;
        cnt0       = resp_cnt;
        req_valid  = 1'b1;
        req_opcode = SB;
        req_addr   = 32'h20;
        req_wdata  = 32'h77;
        guard      = 0;
        do begin
            @(negedge Clk);
            req_valid = 1'b0;
            guard++;
        end while (!mem_wr_en && guard < 20);
        check("rmw reached WR", {31'd0, mem_wr_en}, 32'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        check("rst mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("rst req_ready", {31'd0, req_ready}, 32'd1);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst mem_addr", {2'b00, mem_addr}, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (6) @(negedge Clk);
        check("no resp after reset", resp_cnt - cnt0, 32'd0);
        check("write not retried", wr_done - wr0, 32'd0);
        check("idle after reset", {31'd0, req_ready}, 32'd1);

        run_vec(mk(LW, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 1'b0, 1, 0, 32'h0, 30'h4), "post-reset");

        check("strobes exclusive", {31'd0, both_hi}, 32'd0);
        check("scoreboard drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
